// File: rtl/greater_than_2b.sv
// ---------------------------------------------------------------------------
// greater_than_2b
//   Registered unsigned magnitude comparator. Compares operand i1 against i0
//   and reports which of i1>i0, i1==i0, i1<i0 holds, one cycle after the
//   operands are presented with in_valid=1.
//
//   Ports
//     clk        in   1      rising-edge clock
//     reset      in   1      synchronous, active-high reset
//     i1         in   WIDTH  operand A (unsigned)
//     i0         in   WIDTH  operand B (unsigned)
//     in_valid   in   1      operands valid; result captured when 1
//     gt         out  1      registered: i1 > i0
//     eq         out  1      registered: i1 == i0
//     lt         out  1      registered: i1 < i0
//     out_valid  out  1      registered: high the cycle after a capture
//
//   Parameters
//     WIDTH      operand width in bits (>= 1), default 2
// ---------------------------------------------------------------------------
module greater_than_2b #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i0,
  input  logic             in_valid,
  output logic             gt,
  output logic             eq,
  output logic             lt,
  output logic             out_valid
);

  typedef struct packed {
    logic gt;
    logic eq;
  } cmp_t;

  // Per-bit slice: bit-gt is a&~b, bit-eq is the xnor of the two bits.
  function automatic logic slice_gt(input logic a, input logic b);
    return a & ~b;
  endfunction

  function automatic logic slice_eq(input logic a, input logic b);
    return ~(a ^ b);
  endfunction

  // MSB-first cascade. A slice may only assert gt while every bit above it
  // has compared equal, so the first differing bit decides the result.
  function automatic cmp_t cascade(input logic [WIDTH-1:0] a,
                                   input logic [WIDTH-1:0] b);
    cmp_t r;
    logic above_eq;
    above_eq = 1'b1;
    r.gt     = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      r.gt     = r.gt | (above_eq & slice_gt(a[i], b[i]));
      above_eq = above_eq & slice_eq(a[i], b[i]);
    end
    r.eq = above_eq;
    return r;
  endfunction

  // Stage p0: combinational compare of the incoming operands
  cmp_t cmp_p0;
  logic lt_p0;

  always_comb begin
    cmp_p0 = cascade(i1, i0);
    lt_p0  = ~cmp_p0.gt & ~cmp_p0.eq;
  end

  // Stage p1: result registers; results hold when no capture happens so
  // operands on in_valid=0 cycles never reach the outputs.
  logic gt_q, gt_d;
  logic eq_q, eq_d;
  logic lt_q, lt_d;
  logic vld_p1_q, vld_p1_d;

  always_comb begin
    gt_d     = gt_q;
    eq_d     = eq_q;
    lt_d     = lt_q;
    vld_p1_d = in_valid;
    if (in_valid) begin
      gt_d = cmp_p0.gt;
      eq_d = cmp_p0.eq;
      lt_d = lt_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gt_q     <= 1'b0;
      eq_q     <= 1'b0;
      lt_q     <= 1'b0;
      vld_p1_q <= 1'b0;
    end else begin
      gt_q     <= gt_d;
      eq_q     <= eq_d;
      lt_q     <= lt_d;
      vld_p1_q <= vld_p1_d;
    end
  end

  assign gt        = gt_q;
  assign eq        = eq_q;
  assign lt        = lt_q;
  assign out_valid = vld_p1_q;

endmodule

// File: tb/tb_greater_than_2b.sv
// ---------------------------------------------------------------------------
// tb_greater_than_2b
//   Directed bench for greater_than_2b at WIDTH=2 and WIDTH=4. Results are
//   checked as the packed nibble {gt, eq, lt, out_valid}.
// ---------------------------------------------------------------------------
module tb_greater_than_2b;

  logic       clk;
  logic       reset;
  logic [1:0] a2, b2;
  logic       v2;
  logic       gt2, eq2, lt2, ov2;
  logic [3:0] a4, b4;
  logic       v4;
  logic       gt4, eq4, lt4, ov4;

  int total = 0;
  int bad   = 0;

  greater_than_2b #(.WIDTH(2)) u2 (
    .clk(clk), .reset(reset), .i1(a2), .i0(b2), .in_valid(v2),
    .gt(gt2), .eq(eq2), .lt(lt2), .out_valid(ov2)
  );

  greater_than_2b #(.WIDTH(4)) u4 (
    .clk(clk), .reset(reset), .i1(a4), .i0(b4), .in_valid(v4),
    .gt(gt4), .eq(eq4), .lt(lt4), .out_valid(ov4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed={gt,eq,lt,vld}=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Hand-derived tables for WIDTH=2, bit index = i1*4 + i0.
  logic [15:0] gt_tab;
  logic [15:0] eq_tab;
  logic [3:0]  exp_n;
  int          idx;

  initial begin
    gt_tab = 16'b0111_0011_0001_0000;  // (1,0)(2,0)(2,1)(3,0)(3,1)(3,2)
    eq_tab = 16'b1000_0100_0010_0001;  // diagonal

    // Reset held two cycles with a valid gt-producing compare presented
    reset = 1'b1;
    a2 = 2'd3; b2 = 2'd0; v2 = 1'b1;
    a4 = 4'd8; b4 = 4'd7; v4 = 1'b1;
    tick();
    chk("reset_c1_w2", {gt2, eq2, lt2, ov2}, 4'b0000);
    chk("reset_c1_w4", {gt4, eq4, lt4, ov4}, 4'b0000);
    tick();
    chk("reset_c2_w2", {gt2, eq2, lt2, ov2}, 4'b0000);
    chk("reset_c2_w4", {gt4, eq4, lt4, ov4}, 4'b0000);

    // Exhaustive WIDTH=2, back-to-back valid
    reset = 1'b0;
    v4 = 1'b0;
    for (int x = 0; x < 4; x++) begin
      for (int y = 0; y < 4; y++) begin
        a2 = 2'(x); b2 = 2'(y); v2 = 1'b1;
        tick();
        idx   = x * 4 + y;
        exp_n = {gt_tab[idx], eq_tab[idx], ~gt_tab[idx] & ~eq_tab[idx], 1'b1};
        chk($sformatf("exh_%0d_%0d", x, y), {gt2, eq2, lt2, ov2}, exp_n);
      end
    end

    // Idle cycle: last (3,3) eq result holds, out_valid drops
    v2 = 1'b0; a2 = 2'd0; b2 = 2'd2;
    tick();
    chk("idle_hold_eq", {gt2, eq2, lt2, ov2}, 4'b0100);

    // Latency: (2,1) must not appear before the edge
    a2 = 2'd2; b2 = 2'd1; v2 = 1'b1;
    #2;
    chk("lat_before", {gt2, eq2, lt2, ov2}, 4'b0100);
    tick();
    chk("lat_after", {gt2, eq2, lt2, ov2}, 4'b1001);

    // Hold: capture lt, then ignore operands with in_valid=0
    a2 = 2'd0; b2 = 2'd3; v2 = 1'b1;
    tick();
    chk("hold_cap_lt", {gt2, eq2, lt2, ov2}, 4'b0011);
    a2 = 2'd3; b2 = 2'd0; v2 = 1'b0;
    tick();
    chk("hold_c1", {gt2, eq2, lt2, ov2}, 4'b0010);
    tick();
    chk("hold_c2", {gt2, eq2, lt2, ov2}, 4'b0010);

    // WIDTH=4 regression
    v2 = 1'b0;
    a4 = 4'd8; b4 = 4'd7; v4 = 1'b1;
    tick();
    chk("w4_8_7", {gt4, eq4, lt4, ov4}, 4'b1001);
    a4 = 4'd7; b4 = 4'd8;
    tick();
    chk("w4_7_8", {gt4, eq4, lt4, ov4}, 4'b0011);
    a4 = 4'd15; b4 = 4'd15;
    tick();
    chk("w4_15_15", {gt4, eq4, lt4, ov4}, 4'b0101);
    a4 = 4'd0; b4 = 4'd0;
    tick();
    chk("w4_0_0", {gt4, eq4, lt4, ov4}, 4'b0101);

    // Reset mid-stream wins over a valid compare on the same edge
    a2 = 2'd3; b2 = 2'd1; v2 = 1'b1;
    a4 = 4'd9; b4 = 4'd2; v4 = 1'b1;
    reset = 1'b1;
    tick();
    chk("midrst_w2", {gt2, eq2, lt2, ov2}, 4'b0000);
    chk("midrst_w4", {gt4, eq4, lt4, ov4}, 4'b0000);
    reset = 1'b0; v2 = 1'b0; v4 = 1'b0;
    tick();
    chk("post_rst_idle", {gt2, eq2, lt2, ov2}, 4'b0000);

    // First capture after reset
    a2 = 2'd0; b2 = 2'd0; v2 = 1'b1;
    tick();
    chk("post_rst_eq00", {gt2, eq2, lt2, ov2}, 4'b0101);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
